// File: rtl/wb_pkg.sv
// Shared types for the write-back stage: register index width and write-source encoding.
package wb_pkg;
    localparam int REG_W = 5;

    typedef enum logic {WB_SRC_EXE = 1'b0, WB_SRC_MEM = 1'b1} wb_src_e;
    typedef logic [REG_W-1:0] reg_idx_t;
endpackage

// File: rtl/wb_ldq.sv
// In-order queue of outstanding load destinations, with a per-entry valid bit and the
// OR-reduced busy mask that decode uses to stall on pending loads.
module wb_ldq #(
    parameter int REG_W = 5,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_W-1:0]      pushReg,
    input  logic                  pop,
    output logic [REG_W-1:0]      headReg,
    output logic                  full,
    output logic                  empty,
    output logic [2**REG_W-1:0]   busyMask
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [REG_W-1:0] entryReg [DEPTH];
    logic [DEPTH-1:0] entryVld;
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [CW-1:0]    count;
    logic             pushOk, popOk;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign popOk   = pop & ~empty;
    // A push at full is only legal when the head retires in the same cycle.
    assign pushOk  = push & (~full | popOk);
    assign headReg = entryReg[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entryVld <= '0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
        end else begin
            // Clear before set: at full with push+pop the slot is reused and must stay valid.
            if (popOk) begin
                entryVld[rdPtr] <= 1'b0;
                rdPtr           <= PW'(rdPtr + 1'b1);
            end
            if (pushOk) begin
                entryVld[wrPtr] <= 1'b1;
                wrPtr           <= PW'(wrPtr + 1'b1);
            end
            case ({pushOk, popOk})
                2'b10:   count <= CW'(count + 1'b1);
                2'b01:   count <= CW'(count - 1'b1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) entryReg[wrPtr] <= pushReg;
    end

    always_comb begin
        busyMask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entryVld[i]) busyMask[entryReg[i]] = 1'b1;
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port owner: load returns (unstallable) win over execute results;
// one registered write per cycle, with sticky protocol-error detection.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int N         = 32,
    parameter int REG_W     = wb_pkg::REG_W,
    parameter int LDQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_vld,
    input  logic [REG_W-1:0]    alu_reg,
    input  logic [N-1:0]        alu_data,
    output logic                alu_rdy,
    input  logic                ld_issue,
    input  logic [REG_W-1:0]    ld_reg,
    output logic                ld_full,
    input  logic                mem_rvld,
    input  logic [N-1:0]        mem_rdata,
    output logic                wb_en,
    output logic [REG_W-1:0]    wb_reg,
    output logic [N-1:0]        wb_data,
    output logic                wb_src,
    output logic [2**REG_W-1:0] busy_mask,
    output logic                proto_err
);
    logic [REG_W-1:0] headReg;
    logic             ldqEmpty;
    logic             memGrant;
    logic             errNow;
    wb_src_e          srcSel;

    wb_ldq #(.REG_W(REG_W), .DEPTH(LDQ_DEPTH)) uLdq (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ld_issue),
        .pushReg  (ld_reg),
        .pop      (mem_rvld),
        .headReg  (headReg),
        .full     (ld_full),
        .empty    (ldqEmpty),
        .busyMask (busy_mask)
    );

    // A return against an empty queue has no destination; a same-cycle issue cannot claim it.
    assign memGrant = mem_rvld & ~ldqEmpty;
    assign alu_rdy  = alu_vld & ~mem_rvld & ~busy_mask[alu_reg];
    assign errNow   = (mem_rvld & ldqEmpty) | (ld_issue & ld_full & ~memGrant);
    assign srcSel   = memGrant ? WB_SRC_MEM : WB_SRC_EXE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en     <= 1'b0;
            wb_reg    <= '0;
            wb_data   <= '0;
            wb_src    <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | errNow;
            if (memGrant) begin
                wb_en   <= 1'b1;
                wb_reg  <= headReg;
                wb_data <= mem_rdata;
                wb_src  <= srcSel;
            end else if (alu_rdy) begin
                wb_en   <= 1'b1;
                wb_reg  <= alu_reg;
                wb_data <= alu_data;
                wb_src  <= srcSel;
            end else begin
                wb_en   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench: each driven cycle pushes its expected write into a scoreboard queue;
// a monitor pops one entry per cycle, just after the capturing edge.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_vld = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        alu_rdy;
    logic        ld_issue = 1'b0;
    logic [4:0]  ld_reg = '0;
    logic        ld_full;
    logic        mem_rvld = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_src;
    logic [31:0] busy_mask;
    logic        proto_err;

    typedef struct packed {
        logic        en;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        src;
    } wb_exp_t;

    wb_exp_t expQ[$];
    int vectors = 0;
    int miscompares = 0;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .alu_vld(alu_vld), .alu_reg(alu_reg), .alu_data(alu_data), .alu_rdy(alu_rdy),
        .ld_issue(ld_issue), .ld_reg(ld_reg), .ld_full(ld_full),
        .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .wb_src(wb_src),
        .busy_mask(busy_mask), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: registered outputs checked just after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (expQ.size() != 0) begin
                wb_exp_t e;
                e = expQ.pop_front();
                chk("wb_en", 64'(wb_en), 64'(e.en));
                if (e.en) begin
                    chk("wb_reg", 64'(wb_reg), 64'(e.rg));
                    chk("wb_data", 64'(wb_data), 64'(e.data));
                    chk("wb_src", 64'(wb_src), 64'(e.src));
                end
            end else if (wb_en) begin
                chk("unexpected_write", 64'(wb_en), 64'd0);
            end
        end
    end

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic li, input logic [4:0] lr,
                         input logic mv, input logic [31:0] md);
        @(negedge clk);
        alu_vld = av; alu_reg = ar; alu_data = ad;
        ld_issue = li; ld_reg = lr;
        mem_rvld = mv; mem_rdata = md;
    endtask

    task automatic expWb(input logic en, input logic [4:0] rg, input logic [31:0] d, input logic s);
        wb_exp_t e;
        e.en = en; e.rg = rg; e.data = d; e.src = s;
        expQ.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        expWb(0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_ld_full", 64'(ld_full), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        rst_n = 1'b1;

        // Plain execute write
        drive(1, 3, 32'h1234, 0, 0, 0, 0); expWb(1, 3, 32'h1234, 0);
        #1 chk("exe_alu_rdy", 64'(alu_rdy), 64'd1);

        // Two loads, back-to-back returns
        drive(0, 0, 0, 1, 5, 0, 0); expWb(0, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 0, 0); expWb(0, 0, 0, 0);
        #1 chk("busy_r5", 64'(busy_mask), 64'h20);
        drive(0, 0, 0, 0, 0, 1, 32'hAA); expWb(1, 5, 32'hAA, 1);
        #1 chk("busy_r5r7", 64'(busy_mask), 64'hA0);
        drive(0, 0, 0, 0, 0, 1, 32'hBB); expWb(1, 7, 32'hBB, 1);
        #1 chk("busy_r7", 64'(busy_mask), 64'h80);
        idle();
        #1 chk("busy_clear", 64'(busy_mask), 64'h0);

        // Collision: load return beats execute
        drive(0, 0, 0, 1, 4, 0, 0); expWb(0, 0, 0, 0);
        drive(1, 2, 32'h55, 0, 0, 1, 32'hCC); expWb(1, 4, 32'hCC, 1);
        #1 chk("coll_alu_rdy", 64'(alu_rdy), 64'd0);
        drive(1, 2, 32'h55, 0, 0, 0, 0); expWb(1, 2, 32'h55, 0);
        #1 chk("coll_retry_rdy", 64'(alu_rdy), 64'd1);

        // WAW stall behind pending load to r9
        drive(0, 0, 0, 1, 9, 0, 0); expWb(0, 0, 0, 0);
        drive(1, 9, 32'h99, 0, 0, 0, 0); expWb(0, 0, 0, 0);
        #1 chk("waw_rdy0", 64'(alu_rdy), 64'd0);
        chk("waw_busy", 64'(busy_mask), 64'h200);
        drive(1, 9, 32'h99, 0, 0, 0, 0); expWb(0, 0, 0, 0);
        #1 chk("waw_rdy1", 64'(alu_rdy), 64'd0);
        drive(1, 9, 32'h99, 0, 0, 1, 32'h77); expWb(1, 9, 32'h77, 1);
        #1 chk("waw_rdy2", 64'(alu_rdy), 64'd0);
        drive(1, 9, 32'h99, 0, 0, 0, 0); expWb(1, 9, 32'h99, 0);
        #1 chk("waw_rdy3", 64'(alu_rdy), 64'd1);

        // Fill the queue, overflow, then push+pop at full
        drive(0, 0, 0, 1, 1, 0, 0); expWb(0, 0, 0, 0);
        drive(0, 0, 0, 1, 2, 0, 0); expWb(0, 0, 0, 0);
        drive(0, 0, 0, 1, 3, 0, 0); expWb(0, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 0, 0); expWb(0, 0, 0, 0);
        idle();
        #1 chk("full_set", 64'(ld_full), 64'd1);
        chk("full_proto0", 64'(proto_err), 64'd0);
        chk("full_busy", 64'(busy_mask), 64'h1E);
        drive(0, 0, 0, 1, 6, 0, 0); expWb(0, 0, 0, 0);
        idle();
        #1 chk("ovf_proto", 64'(proto_err), 64'd1);
        chk("ovf_full", 64'(ld_full), 64'd1);
        chk("ovf_busy", 64'(busy_mask), 64'h1E);
        drive(0, 0, 0, 1, 8, 1, 32'h11); expWb(1, 1, 32'h11, 1);
        idle();
        #1 chk("pp_full", 64'(ld_full), 64'd1);
        chk("pp_busy", 64'(busy_mask), 64'h11C);
        drive(0, 0, 0, 0, 0, 1, 32'h22); expWb(1, 2, 32'h22, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h33); expWb(1, 3, 32'h33, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h44); expWb(1, 4, 32'h44, 1);
        drive(0, 0, 0, 0, 0, 1, 32'h88); expWb(1, 8, 32'h88, 1);
        idle();
        #1 chk("drain_full", 64'(ld_full), 64'd0);
        chk("drain_busy", 64'(busy_mask), 64'h0);

        // Mid-cycle reset with two loads pending and a write on the outputs
        drive(0, 0, 0, 1, 10, 0, 0); expWb(0, 0, 0, 0);
        drive(1, 12, 32'hABC, 1, 11, 0, 0); expWb(1, 12, 32'hABC, 0);
        idle();
        #1 chk("pre_rst_busy", 64'(busy_mask), 64'hC00);
        @(negedge clk);
        alu_vld = 0; ld_issue = 0; mem_rvld = 0;
        #2 rst_n = 1'b0;
        #1 chk("arst_wb_en", 64'(wb_en), 64'd0);
        chk("arst_wb_reg", 64'(wb_reg), 64'd0);
        chk("arst_wb_data", 64'(wb_data), 64'd0);
        chk("arst_busy", 64'(busy_mask), 64'd0);
        chk("arst_full", 64'(ld_full), 64'd0);
        chk("arst_proto", 64'(proto_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Return against an empty queue
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD); expWb(0, 0, 0, 0);
        #1 chk("empty_rdy", 64'(alu_rdy), 64'd0);
        idle();
        #1 chk("empty_proto", 64'(proto_err), 64'd1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end
endmodule
